uop_dispatch: RTL and testbench

UOP_DISPATCH -- requirements
Module: uop_dispatch

---
 rtl/uop_dispatch_pkg.sv | 17 +
 rtl/uop_dispatch_bundle_buf.sv | 45 ++++
 rtl/uop_dispatch.sv | 91 +++++++++
 tb/tb_uop_dispatch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uop_dispatch_pkg.sv
// Shared uop types plus the dispatch FSM state and stall-counter types.
package UOP;
    localparam int OUT_UOP           = 4;
    localparam int IDX_W             = $clog2(OUT_UOP);
    localparam int STALL_CNT_W_DEF   = 16;

    typedef logic [15:0]                uop_ins_t;
    typedef logic [3:0]                 uop_size_t;
    typedef logic [IDX_W-1:0]           uop_idx_t;
    typedef logic [STALL_CNT_W_DEF-1:0] stall_cnt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } disp_state_t;
endpackage

// File: rtl/uop_dispatch_bundle_buf.sv
// Local bundle buffer: parallel load, sequential read via an index that
// advances once per accepted uop.
module uop_bundle_buf
    import UOP::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     load,
    input  logic                     advance,
    input  uop_ins_t [0:OUT_UOP-1]   load_bundle,
    input  uop_size_t                load_size,
    output uop_ins_t                 rd_uop,
    output uop_size_t                count
);
    uop_ins_t buf_q [0:OUT_UOP-1];
    uop_idx_t idx;

    // Data needs no reset; only entries below count are ever offered.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < OUT_UOP; i++) begin
                buf_q[i] <= load_bundle[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx   <= '0;
            count <= '0;
        end else if (clear) begin
            idx   <= '0;
            count <= '0;
        end else if (load) begin
            idx   <= '0;
            count <= load_size;
        end else if (advance && count != '0) begin
            idx   <= idx + 1'b1;
            count <= count - 1'b1;
        end
    end

    assign rd_uop = buf_q[idx];
endmodule

// File: rtl/uop_dispatch.sv
// Uop dispatch: fetches bundles from the upstream queue and streams them out
// one uop per handshake. UOP_DISPATCH_PREFETCH_EN overlaps the next fetch with the last uop.
//
// state    | meaning
// ST_EMPTY | buffer empty, request a bundle when the queue has uops
// ST_WAIT  | fetch in flight, bundle is loaded at the end of this cycle
// ST_DRAIN | offering buffered uops downstream
module uop_dispatch
    import UOP::*;
#(
    parameter int STALL_CNT_W = $bits(stall_cnt_t)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  uop_size_t                q_elements,
    output logic                     get_uop,
    input  uop_ins_t [0:OUT_UOP-1]   in_bundle,
    input  uop_size_t                in_bundle_size,
    input  logic                     flush,
    output logic                     disp_valid,
    output uop_ins_t                 disp_uop,
    input  logic                     disp_ready,
    output uop_size_t                buf_count,
    output logic [STALL_CNT_W-1:0]   stall_cnt
);
    disp_state_t state, state_nxt;
    logic fire, last_fire, load, prefetch;

    assign disp_valid = (state == ST_DRAIN);
    assign fire       = disp_valid && disp_ready;
    assign last_fire  = fire && (buf_count == uop_size_t'(1));

`ifdef UOP_DISPATCH_PREFETCH_EN
    assign prefetch = last_fire && (q_elements != '0);
`else
    assign prefetch = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (q_elements != '0) state_nxt = ST_WAIT;
                ST_WAIT:  state_nxt = (in_bundle_size != '0) ? ST_DRAIN : ST_EMPTY;
                ST_DRAIN: if (last_fire) state_nxt = prefetch ? ST_WAIT : ST_EMPTY;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    // get_uop is gated by reset so no request escapes while held in reset.
    always_comb begin
        get_uop = 1'b0;
        load    = 1'b0;
        if (reset && !flush) begin
            case (state)
                ST_EMPTY: get_uop = (q_elements != '0);
                ST_WAIT:  load    = 1'b1;
                ST_DRAIN: get_uop = prefetch;
                default:  get_uop = 1'b0;
            endcase
        end
    end

    uop_bundle_buf u_buf (
        .clk         (clk),
        .reset       (reset),
        .clear       (flush),
        .load        (load),
        .advance     (fire && !flush),
        .load_bundle (in_bundle),
        .load_size   (in_bundle_size),
        .rd_uop      (disp_uop),
        .count       (buf_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (disp_valid && !disp_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uop_dispatch.sv
// Scoreboard bench for uop_dispatch: a queue model feeds bundles, expected
// uops are queued at fetch time and compared on each downstream handshake.
module tb_uop_dispatch;
    import UOP::*;

    localparam int SW = 4;
`ifdef UOP_DISPATCH_PREFETCH_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    uop_size_t              q_elements = '0;
    logic                   get_uop;
    uop_ins_t [0:OUT_UOP-1] in_bundle = '0;
    uop_size_t              in_bundle_size = '0;
    logic                   flush = 1'b0;
    logic                   disp_valid;
    uop_ins_t               disp_uop;
    logic                   disp_ready = 1'b0;
    uop_size_t              buf_count;
    logic [SW-1:0]          stall_cnt;

    int       checks = 0;
    int       errors = 0;
    int       cyc_n  = 0;
    uop_ins_t src_q[$];
    uop_ins_t exp_q[$];
    int       fire_q[$];
    uop_ins_t next_tag = 16'h0100;
    uop_ins_t head;

    uop_dispatch #(.STALL_CNT_W(SW)) dut (
        .clk            (clk),
        .reset          (reset),
        .q_elements     (q_elements),
        .get_uop        (get_uop),
        .in_bundle      (in_bundle),
        .in_bundle_size (in_bundle_size),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_uop       (disp_uop),
        .disp_ready     (disp_ready),
        .buf_count      (buf_count),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Upstream queue: registers a bundle one edge after get_uop.
    always @(posedge clk) begin : queue_model
        int n;
        cyc_n++;
        if (get_uop) begin
            n = (src_q.size() > OUT_UOP) ? OUT_UOP : src_q.size();
            for (int i = 0; i < OUT_UOP; i++) begin
                if (i < n) begin
                    in_bundle[i] <= src_q[0];
                    exp_q.push_back(src_q.pop_front());
                end else begin
                    in_bundle[i] <= '0;
                end
            end
            in_bundle_size <= uop_size_t'(n);
        end
        q_elements <= (src_q.size() > 15) ? 4'd15 : uop_size_t'(src_q.size());
    end

    always @(negedge clk) begin : monitor
        if (reset && disp_valid && disp_ready) begin
            check_eq("exp_avail", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check_eq("disp_uop", disp_uop, exp_q.pop_front());
            fire_q.push_back(cyc_n);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_uops(input int n);
        for (int i = 0; i < n; i++) begin
            src_q.push_back(next_tag);
            next_tag = next_tag + 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        flush = 1'b0;
        disp_ready = 1'b0;
        src_q.delete();
        repeat (2) step();
        exp_q.delete();
        fire_q.delete();
        reset = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 20 && !disp_valid; k++) @(negedge clk);
        check_eq(tag, disp_valid, 1);
    endtask

    task automatic wait_fires(input string tag, input int n);
        for (int k = 0; k < 60 && fire_q.size() < n; k++) @(negedge clk);
        check_eq(tag, fire_q.size(), n);
    endtask

    initial begin
        // Reset values
        do_reset();
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_valid", disp_valid, 0);
        check_eq("rst_get", get_uop, 0);
        check_eq("rst_count", buf_count, 0);
        check_eq("rst_stall", stall_cnt, 0);
        step();
        reset = 1'b1;

        // Three-uop bundle with full throughput and cycle-exact latency
        disp_ready = 1'b1;
        push_uops(3);
        @(negedge clk);
        check_eq("c0_get", get_uop, 0);
        step(); @(negedge clk);
        check_eq("c1_get", get_uop, 1);
        step(); @(negedge clk);
        check_eq("c2_get", get_uop, 0);
        check_eq("c2_valid", disp_valid, 0);
        step(); @(negedge clk);
        check_eq("c3_valid", disp_valid, 1);
        check_eq("c3_count", buf_count, 3);
        repeat (3) begin step(); @(negedge clk); end
        check_eq("c6_valid", disp_valid, 0);
        check_eq("c6_count", buf_count, 0);
        check_eq("c6_get", get_uop, 0);
        check_eq("c6_fires", fire_q.size(), 3);

        // Back-pressure: uop held, stall counter counts, buffer untouched
        do_reset();
        push_uops(OUT_UOP);
        wait_valid("stall_valid");
        head = exp_q.size() > 0 ? exp_q[0] : 16'hffff;
        check_eq("stall_head", disp_uop, head);
        repeat (4) begin
            step(); @(negedge clk);
            check_eq("stall_hold", disp_uop, head);
        end
        step();
        disp_ready = 1'b1;
        @(negedge clk);
        check_eq("stall_cnt5", stall_cnt, 5);
        check_eq("stall_count", buf_count, OUT_UOP);
        wait_fires("stall_drain", OUT_UOP);

        // Flush during WAIT drops the in-flight bundle, then refetch
        do_reset();
        disp_ready = 1'b1;
        push_uops(6);
        @(negedge clk);
        step(); @(negedge clk);
        check_eq("fl_get1", get_uop, 1);
        step();
        flush = 1'b1;
        @(negedge clk);
        check_eq("fl_get_blk", get_uop, 0);
        exp_q.delete();
        step();
        flush = 1'b0;
        @(negedge clk);
        check_eq("fl_valid", disp_valid, 0);
        check_eq("fl_count", buf_count, 0);
        check_eq("fl_refetch", get_uop, 1);
        wait_fires("fl_fires", 2);
        step(); @(negedge clk);
        check_eq("fl_exp_empty", exp_q.size(), 0);

        // Back-to-back bundles: inter-bundle bubble count
        do_reset();
        disp_ready = 1'b1;
        push_uops(8);
        wait_fires("b2b_fires", 8);
        if (fire_q.size() == 8) begin
            check_eq("b2b_intra", fire_q[1] - fire_q[0], 1);
            check_eq("b2b_gap", fire_q[4] - fire_q[3] - 1, GAP);
        end

        // Stall counter saturation, then asynchronous reset mid-DRAIN
        do_reset();
        push_uops(6);
        wait_valid("sat_valid");
        repeat (15) begin step(); @(negedge clk); end
        check_eq("sat_max", stall_cnt, 15);
        step(); @(negedge clk);
        check_eq("sat_hold", stall_cnt, 15);
        step();
        reset = 1'b0;
        #1;
        check_eq("arst_valid", disp_valid, 0);
        check_eq("arst_get", get_uop, 0);
        check_eq("arst_count", buf_count, 0);
        check_eq("arst_stall", stall_cnt, 0);

        // Reset during WAIT abandons the fetch
        do_reset();
        disp_ready = 1'b1;
        push_uops(1);
        @(negedge clk);
        step(); step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_q.delete();
        repeat (4) begin
            @(negedge clk);
            check_eq("wrst_valid", disp_valid, 0);
            step();
        end
        check_eq("wrst_fires", fire_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
